// File: rtl/core_param.sv
// Parametrised single-issue micro-core: one instruction per enabled cycle from an external
// combinational instruction memory, with registered carry/zero flags, output port and HALT.
module core_param #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned PC_W   = 4,
   parameter int unsigned NREG   = 4,
   parameter int unsigned IMM_W  = 4,
   localparam int unsigned RW    = $clog2(NREG),
   localparam int unsigned IW    = 4 + 2 * RW + IMM_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              run_en,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [IW-1:0]     imem_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              carry,
   output logic              zero,
   output logic              halted,
   output logic              illegal
);

   localparam logic [3:0] OpNop  = 4'h0;
   localparam logic [3:0] OpLdi  = 4'h1;
   localparam logic [3:0] OpMov  = 4'h2;
   localparam logic [3:0] OpAdd  = 4'h3;
   localparam logic [3:0] OpSub  = 4'h4;
   localparam logic [3:0] OpAnd  = 4'h5;
   localparam logic [3:0] OpOr   = 4'h6;
   localparam logic [3:0] OpXor  = 4'h7;
   localparam logic [3:0] OpOut  = 4'h8;
   localparam logic [3:0] OpJmp  = 4'h9;
   localparam logic [3:0] OpJc   = 4'hA;
   localparam logic [3:0] OpJz   = 4'hB;
   localparam logic [3:0] OpHalt = 4'hC;

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e state_q, state_d;

   logic [3:0]        op;
   logic [RW-1:0]     rd, rs;
   logic [IMM_W-1:0]  imm;
   logic              exec;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              carry_q, carry_d;
   logic              zero_q, zero_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              illegal_q, illegal_d;

   logic [DATA_W-1:0] rd_val, rs_val, wr_data;
   logic [DATA_W:0]   sum;
   logic              wr_en, flag_upd;

   assign op   = imem_data[IW-1 -: 4];
   assign rd   = imem_data[IMM_W+RW +: RW];
   assign rs   = imem_data[IMM_W +: RW];
   assign imm  = imem_data[IMM_W-1:0];
   assign exec = run_en && (state_q == StRun);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= StRun;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:   if (exec && op == OpHalt) state_d = StHalt;
         StHalt:  state_d = StHalt;
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      halted = (state_q == StHalt);
   end

   // Operand reads see pre-edge register values, so rd==rs uses the old value.
   assign rd_val = regs_q[rd];
   assign rs_val = regs_q[rs];
   assign sum    = {1'b0, rd_val} + {1'b0, rs_val};

   always_comb begin
      pc_d        = pc_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      illegal_d   = illegal_q;
      wr_en       = 1'b0;
      wr_data     = '0;
      flag_upd    = 1'b0;
      if (exec) begin
         pc_d = pc_q + PC_W'(1);
         case (op)
            OpNop, OpHalt: ;
            OpLdi: begin wr_en = 1'b1; wr_data = DATA_W'(imm); end
            OpMov: begin wr_en = 1'b1; wr_data = rs_val; end
            OpAdd: begin
               wr_en = 1'b1; flag_upd = 1'b1;
               wr_data = sum[DATA_W-1:0];
               carry_d = sum[DATA_W];
            end
            OpSub: begin
               wr_en = 1'b1; flag_upd = 1'b1;
               wr_data = rd_val - rs_val;
               carry_d = (rd_val < rs_val);
            end
            OpAnd: begin wr_en = 1'b1; flag_upd = 1'b1; wr_data = rd_val & rs_val; carry_d = 1'b0; end
            OpOr:  begin wr_en = 1'b1; flag_upd = 1'b1; wr_data = rd_val | rs_val; carry_d = 1'b0; end
            OpXor: begin wr_en = 1'b1; flag_upd = 1'b1; wr_data = rd_val ^ rs_val; carry_d = 1'b0; end
            OpOut: begin out_data_d = rd_val; out_valid_d = 1'b1; end
            OpJmp: pc_d = imm[PC_W-1:0];
            OpJc:  if (carry_q) pc_d = imm[PC_W-1:0];
            OpJz:  if (zero_q)  pc_d = imm[PC_W-1:0];
            default: illegal_d = 1'b1;
         endcase
         if (flag_upd) zero_d = (wr_data == '0);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_q        <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      end else begin
         pc_q        <= pc_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         illegal_q   <= illegal_d;
         if (wr_en) regs_q[rd] <= wr_data;
      end
   end

   assign imem_addr = pc_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_core_param.sv
// Bench for core_param: an 8-bit and a 4-bit instance run small programs; OUT results are
// matched against a queue of expected values, state checked directly at negedge.
module tb_core_param;

   logic        clk = 1'b0;
   logic        resetn;
   logic        run_en;

   logic [3:0]  addr8, addr4;
   logic [11:0] data8, data4;
   logic [7:0]  out_data8;
   logic [3:0]  out_data4;
   logic        out_valid8, out_valid4, carry8, carry4, zero8, zero4;
   logic        halted8, halted4, illegal8, illegal4;

   logic [11:0] mem8 [16];
   logic [11:0] mem4 [16];
   logic [7:0]  q8 [$];
   logic [3:0]  q4 [$];

   int n_checks = 0;
   int n_fail   = 0;
   int pulses8  = 0;
   int pulses4  = 0;

   localparam logic [3:0] LDI = 4'h1, ADD = 4'h3, SUB = 4'h4, OUT = 4'h8, JMP = 4'h9;
   localparam logic [3:0] JC = 4'hA, JZ = 4'hB, HALT = 4'hC;

   assign data8 = mem8[addr8];
   assign data4 = mem4[addr4];

   always #5 clk = ~clk;

   core_param #(.DATA_W(8), .PC_W(4), .NREG(4), .IMM_W(4)) u_dut8 (
      .clk       (clk),
      .resetn    (resetn),
      .run_en    (run_en),
      .imem_addr (addr8),
      .imem_data (data8),
      .out_data  (out_data8),
      .out_valid (out_valid8),
      .carry     (carry8),
      .zero      (zero8),
      .halted    (halted8),
      .illegal   (illegal8)
   );

   core_param #(.DATA_W(4), .PC_W(4), .NREG(4), .IMM_W(4)) u_dut4 (
      .clk       (clk),
      .resetn    (resetn),
      .run_en    (run_en),
      .imem_addr (addr4),
      .imem_data (data4),
      .out_data  (out_data4),
      .out_valid (out_valid4),
      .carry     (carry4),
      .zero      (zero4),
      .halted    (halted4),
      .illegal   (illegal4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [3:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold in reset, clear both program memories.
   task automatic enter_reset();
      resetn = 1'b0;
      run_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mem8[i] = '0;
         mem4[i] = '0;
      end
      step(1);
   endtask

   task automatic release_reset();
      pulses8 = 0;
      pulses4 = 0;
      resetn  = 1'b1;
      run_en  = 1'b1;
   endtask

   always @(negedge clk) begin
      if (resetn && out_valid8) begin
         pulses8++;
         check("out8_pending", 32'(q8.size() > 0), 32'd1);
         if (q8.size() > 0) check("out8_data", out_data8, q8.pop_front());
      end
      if (resetn && out_valid4) begin
         pulses4++;
         check("out4_pending", 32'(q4.size() > 0), 32'd1);
         if (q4.size() > 0) check("out4_data", out_data4, q4.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state.
      enter_reset();
      check("rst_pc", addr8, 0);
      check("rst_out", {out_data8, out_valid8, carry8, zero8, halted8, illegal8}, 0);

      // 8-bit add/out; 4-bit add with carry then taken JC.
      mem8[0] = enc(LDI, 0, 0, 7);
      mem8[1] = enc(LDI, 1, 0, 9);
      mem8[2] = enc(ADD, 0, 1, 0);
      mem8[3] = enc(OUT, 0, 0, 0);
      mem8[4] = enc(JMP, 0, 0, 4);
      mem4[0] = enc(LDI, 0, 0, 15);
      mem4[1] = enc(LDI, 1, 0, 1);
      mem4[2] = enc(ADD, 0, 1, 0);
      mem4[3] = enc(JC, 0, 0, 6);
      mem4[4] = enc(OUT, 1, 0, 0);
      mem4[6] = enc(OUT, 0, 0, 0);
      mem4[7] = enc(JMP, 0, 0, 7);
      q8.push_back(8'h10);
      q4.push_back(4'h0);
      release_reset();
      step(3);
      check("p1_pc8", addr8, 3);
      check("p1_valid8_early", out_valid8, 0);
      check("p1_carry4", carry4, 1);
      check("p1_zero4", zero4, 1);
      step(1);
      check("p1_valid8", out_valid8, 1);
      check("p1_data8", out_data8, 8'h10);
      check("p1_flags8", {carry8, zero8}, 2'b00);
      check("p1_jc_taken", addr4, 6);
      step(6);
      check("p1_pulses8", pulses8, 1);
      check("p1_pulses4", pulses4, 1);
      check("p1_q8_drained", q8.size(), 0);
      check("p1_q4_drained", q4.size(), 0);

      // 8-bit SUB borrow, SUB to zero, JZ, back-to-back OUT; 4-bit JC not taken.
      enter_reset();
      mem8[0]  = enc(LDI, 0, 0, 3);
      mem8[1]  = enc(LDI, 1, 0, 5);
      mem8[2]  = enc(SUB, 0, 1, 0);
      mem8[3]  = enc(OUT, 0, 0, 0);
      mem8[4]  = enc(SUB, 1, 1, 0);
      mem8[5]  = enc(JZ, 0, 0, 9);
      mem8[6]  = enc(OUT, 1, 0, 0);
      mem8[9]  = enc(OUT, 1, 0, 0);
      mem8[10] = enc(OUT, 0, 0, 0);
      mem8[11] = enc(JMP, 0, 0, 11);
      mem4[0]  = enc(LDI, 0, 0, 15);
      mem4[1]  = enc(LDI, 1, 0, 0);
      mem4[2]  = enc(ADD, 0, 1, 0);
      mem4[3]  = enc(JC, 0, 0, 6);
      mem4[4]  = enc(OUT, 0, 0, 0);
      mem4[5]  = enc(JMP, 0, 0, 5);
      mem4[6]  = enc(OUT, 1, 0, 0);
      q8.push_back(8'hFE);
      q8.push_back(8'h00);
      q8.push_back(8'hFE);
      q4.push_back(4'hF);
      release_reset();
      step(3);
      check("p2_borrow", carry8, 1);
      check("p2_zero_nz", zero8, 0);
      check("p2_flags4", {carry4, zero4}, 2'b00);
      step(1);
      check("p2_jc_not_taken", addr4, 4);
      step(1);
      check("p2_sub_zero", {carry8, zero8}, 2'b01);
      step(1);
      check("p2_jz_taken", addr8, 9);
      step(1);
      check("p2_b2b_1", out_valid8, 1);
      step(1);
      check("p2_b2b_2", out_valid8, 1);
      step(1);
      check("p2_b2b_end", out_valid8, 0);
      step(3);
      check("p2_pulses8", pulses8, 3);
      check("p2_pulses4", pulses4, 1);
      check("p2_q8_drained", q8.size(), 0);
      check("p2_q4_drained", q4.size(), 0);

      // Stall at pc 15 for two cycles, then OUT executes and pc wraps.
      enter_reset();
      mem8[0]  = enc(JMP, 0, 0, 14);
      mem8[14] = enc(LDI, 0, 0, 11);
      mem8[15] = enc(OUT, 0, 0, 0);
      release_reset();
      step(2);
      check("p3_pc15", addr8, 15);
      run_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step(1);
         check("p3_stall_pc", addr8, 15);
         check("p3_stall_valid", out_valid8, 0);
         check("p3_stall_data", out_data8, 0);
      end
      q8.push_back(8'd11);
      run_en = 1'b1;
      step(1);
      run_en = 1'b0;
      check("p3_wrap", addr8, 0);
      check("p3_valid", out_valid8, 1);
      step(2);
      check("p3_pulses8", pulses8, 1);
      check("p3_q8_drained", q8.size(), 0);

      // Illegal opcode, HALT held for 20 cycles, then asynchronous reset mid-cycle.
      enter_reset();
      mem8[0] = enc(LDI, 0, 0, 5);
      mem8[1] = enc(4'hE, 1, 2, 3);
      mem8[2] = enc(OUT, 0, 0, 0);
      mem8[3] = enc(HALT, 0, 0, 0);
      mem8[4] = enc(OUT, 0, 0, 0);
      q8.push_back(8'd5);
      release_reset();
      step(2);
      check("p4_illegal", illegal8, 1);
      check("p4_illegal_pc", addr8, 2);
      step(2);
      check("p4_halted", halted8, 1);
      for (int i = 0; i < 20; i++) begin
         run_en = 1'($urandom_range(0, 1));
         step(1);
         check("p4_halt_pc", addr8, 4);
         check("p4_halt_valid", out_valid8, 0);
         check("p4_halt_state", halted8, 1);
      end
      check("p4_pulses8", pulses8, 1);
      #2;
      resetn = 1'b0;
      #1;
      check("p4_async_pc", addr8, 0);
      check("p4_async_out", {out_data8, out_valid8, carry8, zero8, halted8, illegal8}, 0);
      step(1);
      release_reset();
      step(1);
      check("p4_restart_pc", addr8, 1);
      check("p4_restart_state", {halted8, illegal8}, 2'b00);
      check("p4_q8_drained", q8.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_param.md
Name: core_param

Overview:
- Parametrised successor to the team's 4-bit accumulator core.
- Single-issue, single-cycle-execute micro-core with generic data width, PC width, register-file depth and immediate width.
- Adds a full ALU op set, registered carry/zero flags, conditional jumps on either flag, an output port with valid strobe, a stall input, HALT and illegal-opcode detection.
- Instruction memory is external: the core drives the address and receives combinational read data in the same cycle.

Parameters:
- DATA_W, 8, register/ALU/output data width (>=2).
- PC_W, 4, program counter width; program space 2^PC_W words.
- NREG, 4, number of general registers (power of two, >=2); RW = log2(NREG).
- IMM_W, 4, immediate field width; must satisfy PC_W <= IMM_W <= DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- run_en  in  1  1 = execute the instruction at imem_addr this cycle; 0 = stall, no state change.
- imem_addr  out  PC_W  current PC.
- imem_data  in  IW  instruction at imem_addr; IW = 4 + 2*RW + IMM_W.
- out_data  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse the cycle after an OUT executes.
- carry  out  1  registered carry/borrow flag.
- zero  out  1  registered zero flag.
- halted  out  1  core is in HALT state.
- illegal  out  1  sticky flag: an undefined opcode has been executed.

Behaviour:
- Instruction fields, MSB to LSB: op[3:0], rd[RW-1:0], rs[RW-1:0], imm[IMM_W-1:0].
- Reset (async, any time, including mid-program): pc=0, all registers=0, carry=0, zero=0, out_data=0, out_valid=0, halted=0, illegal=0, state=RUN.
- States:
  - RUN: executes one instruction per cycle when run_en=1.
  - RUN -> HALT on HALT opcode. In HALT, pc, registers and flags hold, out_valid=0, run_en is ignored.
  - Only reset leaves HALT.
- Stall: with run_en=0 in RUN, all state holds and out_valid=0 the next cycle.
- Register reads are combinational from pre-edge values. A write lands at the edge, so rd==rs uses the old value.
- Ops:
  - 0 NOP.
  - 1 LDI: rd<=zext(imm).
  - 2 MOV: rd<=rs.
  - 3 ADD: rd<=rd+rs; carry<=carry-out of DATA_W sum.
  - 4 SUB: rd<=rd-rs; carry<=1 iff rd<rs unsigned (borrow).
  - 5 AND, 6 OR, 7 XOR: rd<=rd op rs; carry<=0.
  - 8 OUT: out_data<=rd; out_valid=1 for exactly the following cycle.
  - 9 JMP: pc<=imm[PC_W-1:0].
  - A JC: jump if carry=1.
  - B JZ: jump if zero=1.
  - C HALT.
  - D-F: treated as NOP and set illegal (sticky until reset).
- zero<=(result==0) for ops 3-7 only. LDI and MOV leave both flags unchanged; all other ops leave flags unchanged.
- Flags are registered: a JC/JZ sees flags produced by an earlier executed instruction, never by itself.
- PC:
  - Non-taken or non-jump instructions: pc<=pc+1, wrapping from 2^PC_W-1 to 0.
  - Taken jump: pc<=target. A jump to its own address loops forever with no other effect.
- out_valid is registered. Back-to-back OUTs give back-to-back valid pulses, each with the new out_data.
- Arithmetic is unsigned modulo 2^DATA_W. There are no exceptions other than illegal.

Test Plan:
- Defaults (DATA_W=8): LDI r0,7; LDI r1,9; ADD r0,r1; OUT r0 -> out_data=0x10 with a single out_valid pulse in cycle 5; carry=0, zero=0.
- DATA_W=4: LDI r0,15; LDI r1,1; ADD r0,r1; JC 6 -> r0=0, carry=1, zero=1, pc=6 next cycle. Repeat with r1=0 -> JC not taken, pc increments.
- SUB borrow: LDI r0,3; LDI r1,5; SUB r0,r1 -> r0=0xFE, carry=1. Then SUB r1,r1 -> r1=0, zero=1, carry=0; JZ taken.
- Stall and wrap: PC at 15 with run_en toggling 1,0,0,1 -> pc holds for two cycles then wraps to 0; no register or out_valid changes while stalled.
- HALT, illegal and reset: op 0xE executes -> illegal=1 and pc increments. HALT -> halted=1, pc frozen for 20 cycles regardless of run_en. Assert resetn low mid-HALT -> all outputs 0 immediately (asynchronously), and execution restarts at pc=0 after release.
